pc_sequencer: RTL and testbench

- Fetch-stage controller for the 3-stage RV32 pipeline.
- Sequences the program counter register: generates its enable and next-value, arbitrates sequential fetch, taken branches and traps, and honours pipeline stalls.
- Runs the instruction-memory request/ready handshake and squashes stale fetches after redirects.
- Sits between the EX-stage branch/trap logic, the hazard unit and the PC register / instruction memory.

---
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer for the 3-stage RV32 pipeline: boot delay, sequential fetch,
// branch/trap redirects, stall handling and the instruction-memory handshake.
module pc_sequencer #(
  parameter int unsigned      Width       = 32,
  parameter logic [Width-1:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [Width-1:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned      BOOT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] pc,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [Width-1:0] branch_target,
  input  logic             trap_req,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic [Width-1:0] pc_next,
  output logic             imem_req,
  output logic             fetch_valid,
  output logic             flush,
  output logic             boot_done
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StDrain
  } state_e;

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;

  logic             redirect;
  logic [Width-1:0] redirect_pc;
  logic [Width-1:0] pc_seq;

  // Branch targets are word-aligned by force; the low bits are intentionally dropped.
  logic unused_target_lsb;
  assign unused_target_lsb = ^branch_target[1:0];

  assign redirect    = trap_req | branch_taken;
  assign redirect_pc = trap_req ? TRAP_VEC : {branch_target[Width-1:2], 2'b00};
  assign pc_seq      = pc + Width'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StBoot;
      boot_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_en       = 1'b0;
    pc_next     = RESET_VEC;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      StBoot: begin
        if (boot_cnt_q == BootLast) begin
          pc_en   = 1'b1;
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      StRun: begin
        pc_next = pc_seq;
        if (redirect) begin
          pc_en   = 1'b1;
          pc_next = redirect_pc;
          flush   = 1'b1;
          // An unanswered fetch is still in flight; its response must be dropped.
          if (!imem_ready) begin
            state_d = StDrain;
          end
        end else begin
          imem_req = 1'b1;
          if (!stall) begin
            pc_en       = imem_ready;
            fetch_valid = imem_ready;
          end
        end
      end

      StDrain: begin
        pc_next = pc_seq;
        if (redirect) begin
          pc_en   = 1'b1;
          pc_next = redirect_pc;
          flush   = 1'b1;
        end
        // The stale response retires the outstanding fetch even alongside a redirect,
        // otherwise nothing would ever answer and DRAIN would never exit.
        if (imem_ready) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d    = StBoot;
        boot_cnt_d = 4'd0;
      end
    endcase

    if (!reset) begin
      pc_en       = 1'b0;
      pc_next     = RESET_VEC;
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
      flush       = 1'b0;
    end
  end

  assign boot_done = reset & (state_q != StBoot);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle expectations queued at drive time and
// checked against the DUT on the following falling edge.
module tb_pc_sequencer;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  pc;
  logic          stall;
  logic          branch_taken;
  logic [W-1:0]  branch_target;
  logic          trap_req;
  logic          imem_ready;
  logic          pc_en;
  logic [W-1:0]  pc_next;
  logic          imem_req;
  logic          fetch_valid;
  logic          flush;
  logic          boot_done;

  always #5 clk = ~clk;

  pc_sequencer #(
    .Width      (W),
    .RESET_VEC  (32'h0000_0000),
    .TRAP_VEC   (32'h0000_0100),
    .BOOT_CYCLES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .trap_req     (trap_req),
    .imem_ready   (imem_ready),
    .pc_en        (pc_en),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .boot_done    (boot_done)
  );

  typedef struct {
    string        tag;
    logic         en;
    logic [31:0]  nxt;
    logic         chk_nxt;
    logic         req;
    logic         fv;
    logic         fl;
    logic         bd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic st, input logic bt,
                       input logic [31:0] tgt, input logic tr, input logic rdy);
    pc            = p;
    stall         = st;
    branch_taken  = bt;
    branch_target = tgt;
    trap_req      = tr;
    imem_ready    = rdy;
  endtask

  task automatic expect_out(input string tag, input logic en, input logic [31:0] nxt,
                            input logic chk_nxt, input logic req, input logic fv,
                            input logic fl, input logic bd);
    exp_t e;
    e.tag     = tag;
    e.en      = en;
    e.nxt     = nxt;
    e.chk_nxt = chk_nxt;
    e.req     = req;
    e.fv      = fv;
    e.fl      = fl;
    e.bd      = bd;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "pc_en", 32'(pc_en), 32'(e.en));
      if (e.chk_nxt) chk(e.tag, "pc_next", pc_next, e.nxt);
      chk(e.tag, "imem_req", 32'(imem_req), 32'(e.req));
      chk(e.tag, "fetch_valid", 32'(fetch_valid), 32'(e.fv));
      chk(e.tag, "flush", 32'(flush), 32'(e.fl));
      chk(e.tag, "boot_done", 32'(boot_done), 32'(e.bd));
    end
  endtask

  // Sample on the falling edge, then return just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_out("rst_hold", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end

    // Boot
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("boot1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    expect_out("boot2", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      expect_out("seq", 1'b1, 32'(4 * i + 4), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc();
    end

    // Wait states
    for (int i = 0; i < 3; i++) begin
      drive(32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      expect_out("wait", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    drive(32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("wait_done", 1'b1, 32'h14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cyc();

    // Stall vs branch
    drive(32'h14, 1'b1, 1'b1, 32'h203, 1'b0, 1'b1);
    expect_out("stall_br", 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); cyc();
    drive(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("stall", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
    drive(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("post_stall", 1'b1, 32'h204, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cyc();

    // Trap/branch collision and wrap
    drive(32'h204, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    expect_out("collide", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); cyc();
    drive(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("wrap", 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cyc();

    // Redirect during wait
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("pre_trap", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("trap_wait", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("drain_stale", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("refetch", 1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cyc();

    // Redirects while draining
    drive(32'h104, 1'b0, 1'b1, 32'h3FF, 1'b0, 1'b0);
    expect_out("br_wait", 1'b1, 32'h3FC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); cyc();
    drive(32'h3FC, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("drain_trap", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_out("drain_stay", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();

    // Asynchronous reset mid-cycle while in DRAIN
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("pre_areset", "pc_en", 32'(pc_en), 32'h1);
    chk("pre_areset", "boot_done", 32'(boot_done), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("areset", "pc_en", 32'(pc_en), 32'h0);
    chk("areset", "pc_next", pc_next, 32'h0);
    chk("areset", "imem_req", 32'(imem_req), 32'h0);
    chk("areset", "fetch_valid", 32'(fetch_valid), 32'h0);
    chk("areset", "flush", 32'(flush), 32'h0);
    chk("areset", "boot_done", 32'(boot_done), 32'h0);
    @(posedge clk);
    #1;
    expect_out("rst_hold2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc();

    // Second boot ignores redirects and stall
    reset = 1'b1;
    drive(32'h100, 1'b1, 1'b1, 32'h500, 1'b1, 1'b1);
    expect_out("reboot1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    expect_out("reboot2", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expect_out("reboot_seq", 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cyc();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
